pipelined_control_unit: RTL and testbench

Registered, multi-cycle successor to the combinational instruction decoder. It accepts 9-bit instructions through a valid/ready handshake and decodes them into the datapath control signals, with one cycle of latency. Loads and stores are stretched over a parametrised memory latency. A halt instruction produces a sticky done, and a retired-instruction counter is maintained. It sits between instruction fetch and the register file/ALU/data memory.

---
 rtl/pipelined_control_unit.sv | 136 +++++++++++++
 tb/tb_pipelined_control_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// Registered instruction decoder with a valid/ready front end, memory-latency
// stretching for loads/stores, a sticky halt and a saturating retire counter.
module pipelined_control_unit #(
  parameter int         MEM_LAT = 1,
  parameter int         CNT_W   = 16,
  parameter logic [8:0] HALT_OP = 9'b010000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [8:0]       instruction,
  output logic             instr_ready,
  output logic             ctrl_valid,
  output logic             branch_en,
  output logic             write_en,
  output logic             mem_read,
  output logic             mem_write,
  output logic             use_immediate,
  output logic             write_reg_en,
  output logic             special_en,
  output logic             done,
  output logic [CNT_W-1:0] retired_count
);
  localparam int LAT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {RUN, MEM, HALT} state_t;

  state_t           state, state_nx;
  logic [LAT_W-1:0] lat_cnt, lat_cnt_nx;
  logic             is_store, is_store_nx;
  logic             accept_mode, xfer, is_move;
  logic             ctrl_valid_nx, branch_en_nx, write_en_nx, mem_read_nx, mem_write_nx;
  logic             use_immediate_nx, write_reg_en_nx, special_en_nx, done_nx;

  // The last cycle of a memory stretch behaves exactly like RUN, which gives
  // back-to-back acceptance without a dedicated turnaround state.
  assign accept_mode = (state == RUN) || (state == MEM && lat_cnt == LAT_W'(MEM_LAT));
  assign instr_ready = rst_n & accept_mode;
  assign xfer        = instr_valid & instr_ready;
  assign is_move     = (instruction[8:5] == 4'b0000) && (instruction[3:2] > instruction[1:0]);

  always_comb begin
    state_nx         = state;
    lat_cnt_nx       = lat_cnt;
    is_store_nx      = is_store;
    ctrl_valid_nx    = 1'b0;
    branch_en_nx     = 1'b0;
    write_en_nx      = 1'b0;
    mem_read_nx      = 1'b0;
    mem_write_nx     = 1'b0;
    use_immediate_nx = 1'b0;
    write_reg_en_nx  = 1'b0;
    special_en_nx    = 1'b0;
    done_nx          = 1'b0;
    if (accept_mode) begin
      state_nx = RUN;
      if (xfer) begin
        ctrl_valid_nx = 1'b1;
        if (instruction == HALT_OP) begin
          done_nx  = 1'b1;
          state_nx = HALT;
        end else begin
          case (instruction[8:7])
            2'b00: begin
              write_en_nx     = 1'b1;
              write_reg_en_nx = is_move;
              special_en_nx   = is_move;
            end
            2'b01: branch_en_nx = 1'b1;
            2'b10: begin
              write_en_nx      = 1'b1;
              use_immediate_nx = 1'b1;
            end
            default: begin
              mem_write_nx = instruction[6];
              mem_read_nx  = !instruction[6];
              if (MEM_LAT == 1) begin
                write_en_nx     = !instruction[6];
                write_reg_en_nx = !instruction[6];
              end else begin
                ctrl_valid_nx = 1'b0;
                state_nx      = MEM;
                lat_cnt_nx    = LAT_W'(1);
                is_store_nx   = instruction[6];
              end
            end
          endcase
        end
      end
    end else if (state == MEM) begin
      lat_cnt_nx   = lat_cnt + LAT_W'(1);
      mem_read_nx  = !is_store;
      mem_write_nx = is_store;
      if (lat_cnt_nx == LAT_W'(MEM_LAT)) begin
        ctrl_valid_nx   = 1'b1;
        write_en_nx     = !is_store;
        write_reg_en_nx = !is_store;
      end
    end else begin
      done_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= RUN;
      lat_cnt       <= '0;
      is_store      <= 1'b0;
      ctrl_valid    <= 1'b0;
      branch_en     <= 1'b0;
      write_en      <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      use_immediate <= 1'b0;
      write_reg_en  <= 1'b0;
      special_en    <= 1'b0;
      done          <= 1'b0;
      retired_count <= '0;
    end else begin
      state         <= state_nx;
      lat_cnt       <= lat_cnt_nx;
      is_store      <= is_store_nx;
      ctrl_valid    <= ctrl_valid_nx;
      branch_en     <= branch_en_nx;
      write_en      <= write_en_nx;
      mem_read      <= mem_read_nx;
      mem_write     <= mem_write_nx;
      use_immediate <= use_immediate_nx;
      write_reg_en  <= write_reg_en_nx;
      special_en    <= special_en_nx;
      done          <= done_nx;
      if (ctrl_valid && retired_count != {CNT_W{1'b1}})
        retired_count <= retired_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Two units (MEM_LAT=1/CNT_W=3 and MEM_LAT=3/CNT_W=4) share one stimulus stream;
// each is checked against a per-cycle output schedule plus a control-word queue.
module tb_pipelined_control_unit;
  localparam int         LAT0 = 1, LAT1 = 3;
  localparam logic [8:0] HALT = 9'h080;

  logic       clk = 1'b0;
  logic       rst_n, instr_valid;
  logic [8:0] instruction;
  logic [1:0] rdy, cv, br, we, mr, mw, ui, wr, sp, dn;
  logic [2:0] cnt0;
  logic [3:0] cnt1;

  always #5 clk = ~clk;

  pipelined_control_unit #(.MEM_LAT(LAT0), .CNT_W(3), .HALT_OP(HALT)) u0 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instruction(instruction),
    .instr_ready(rdy[0]), .ctrl_valid(cv[0]), .branch_en(br[0]), .write_en(we[0]),
    .mem_read(mr[0]), .mem_write(mw[0]), .use_immediate(ui[0]), .write_reg_en(wr[0]),
    .special_en(sp[0]), .done(dn[0]), .retired_count(cnt0));

  pipelined_control_unit #(.MEM_LAT(LAT1), .CNT_W(4), .HALT_OP(HALT)) u1 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instruction(instruction),
    .instr_ready(rdy[1]), .ctrl_valid(cv[1]), .branch_en(br[1]), .write_en(we[1]),
    .mem_read(mr[1]), .mem_write(mw[1]), .use_immediate(ui[1]), .write_reg_en(wr[1]),
    .special_en(sp[1]), .done(dn[1]), .retired_count(cnt1));

  int checks = 0, errors = 0, cyc = 0;
  // Expected {ctrl_valid,branch,write_en,mem_read,mem_write,use_imm,write_reg,special}
  // for each cycle; cycle c is the period following rising edge c.
  logic [7:0] sched [2][4096];
  bit         halted [2];
  int         halt_from [2], next_free [2], exp_cnt [2];
  logic [7:0] q0[$], q1[$];

  function automatic int lat(int d);  return (d == 0) ? LAT0 : LAT1; endfunction
  function automatic int cmax(int d); return (d == 0) ? 7 : 15;      endfunction

  function automatic bit model_ready(int d, int p);
    return rst_n && !halted[d] && p >= next_free[d];
  endfunction

  function automatic logic [7:0] decode(logic [8:0] ins);
    logic [7:0] w;
    w = 8'h80;
    if (ins == HALT) return w;
    case (ins[8:7])
      2'd0: begin
        w[5] = 1'b1;
        if (ins inside {9'h004, 9'h008, 9'h00C, 9'h009, 9'h00D, 9'h00E,
                        9'h014, 9'h018, 9'h01C, 9'h019, 9'h01D, 9'h01E}) begin
          w[1] = 1'b1; w[0] = 1'b1;
        end
      end
      2'd1: w[6] = 1'b1;
      2'd2: begin w[5] = 1'b1; w[2] = 1'b1; end
      default: if (ins[6]) w[3] = 1'b1;
               else begin w[4] = 1'b1; w[5] = 1'b1; w[1] = 1'b1; end
    endcase
    return w;
  endfunction

  task automatic accept(int d, int c, logic [8:0] ins);
    logic [7:0] w;
    int L;
    w = decode(ins);
    if (d == 0) q0.push_back(w); else q1.push_back(w);
    if (ins == HALT) begin
      sched[d][c]  = w;
      halted[d]    = 1'b1;
      halt_from[d] = c;
    end else begin
      L = (ins[8:7] == 2'b11) ? lat(d) : 1;
      for (int p = c; p < c + L - 1; p++) sched[d][p] = w & 8'b0001_1000;
      sched[d][c+L-1] = w;
      next_free[d]    = c + L - 1;
    end
  endtask

  // Reference model: advances on each rising edge using the inputs of the previous cycle.
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        halted[d] = 1'b0; next_free[d] = 0; exp_cnt[d] = 0;
        if (d == 0) q0.delete(); else q1.delete();
        for (int p = cyc; p < cyc + 16; p++) sched[d][p] = 8'h00;
      end else begin
        if (sched[d][cyc-1][7] && exp_cnt[d] != cmax(d)) exp_cnt[d] = exp_cnt[d] + 1;
        if (instr_valid && model_ready(d, cyc - 1)) accept(d, cyc, instruction);
      end
    end
  end

  task automatic chk(string name, int d, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d cyc=%0d actual=%h expected=%h", name, d, cyc, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle, pops the scoreboard on every ctrl_valid.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int d = 0; d < 2; d++) begin
        logic [7:0] act, w;
        act = {cv[d], br[d], we[d], mr[d], mw[d], ui[d], wr[d], sp[d]};
        chk("ready", d, 16'(rdy[d]), 16'(model_ready(d, cyc)));
        chk("ctrl",  d, 16'(act), 16'(sched[d][cyc]));
        chk("done",  d, 16'(dn[d]), 16'(halted[d] && cyc >= halt_from[d]));
        if (d == 0) chk("count", d, 16'(cnt0), 16'(exp_cnt[d]));
        else        chk("count", d, 16'(cnt1), 16'(exp_cnt[d]));
        if (cv[d] === 1'b1) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checks++; errors++;
            $display("FAIL scoreboard u%0d cyc=%0d actual=ctrl_valid expected=no pending word", d, cyc);
          end else begin
            w = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("word", d, 16'(act), 16'(w));
          end
        end
      end
    end
  end

  task automatic step(bit v, logic [8:0] ins, bit r);
    @(posedge clk);
    #2;
    instr_valid = v; instruction = ins; rst_n = r;
  endtask

  logic [8:0] ops [20] = '{9'h0A5, 9'h0C5, 9'h105, 9'h004, 9'h008, 9'h00C, 9'h009,
                           9'h00D, 9'h00E, 9'h014, 9'h018, 9'h01C, 9'h019, 9'h01D,
                           9'h01E, 9'h001, 9'h010, 9'h185, 9'h1C5, 9'h185};

  initial begin
    logic [8:0] ins;
    int r;
    rst_n = 1'b0; instr_valid = 1'b0; instruction = '0;
    repeat (3) step(0, 9'h000, 0);
    step(0, 9'h000, 1);
    // Each op held three cycles: one acceptance per memory op on the slow unit.
    foreach (ops[i]) repeat (3) step(1, ops[i], 1);
    step(0, 9'h000, 1);
    // Halt, then instructions that must be ignored, then reset clears done.
    repeat (2) step(1, HALT, 1);
    repeat (10) step(1, 9'h0A5, 1);
    repeat (2) step(0, 9'h000, 0);
    step(0, 9'h000, 1);
    // Load, then reset during its second memory cycle.
    step(1, 9'h185, 1);
    step(0, 9'h000, 1);
    step(0, 9'h000, 0);
    step(0, 9'h000, 1);
    // Counter saturation.
    repeat (12) step(1, 9'h0A5, 1);
    step(0, 9'h000, 1);
    repeat (1500) begin
      r = $urandom_range(0, 99);
      ins = 9'($urandom());
      if ($urandom_range(0, 49) == 0) ins = HALT;
      if (r < 2) step(0, ins, 0);
      else       step(r % 4 != 0, ins, 1);
    end
    repeat (5) step(0, 9'h000, 1);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
